alu_arbiter: RTL

Sequencer and two-way arbiter sharing the single `alu` instance between two requesters, e.g. the switch front-end and a self-test pattern generator. It accepts operand/opcode requests over a req/gnt handshake, arbitrates round-robin, and drives the `alu_if` modport from registered operands. It captures `out`, `zf`, `nf` and `of` one cycle later and holds them until the owning requester acknowledges.

---
 rtl/cpu_types_pkg.sv | 34 +++
 rtl/alu_if.sv | 24 ++
 rtl/alu_arbiter_rr_pick2.sv | 22 ++
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word and ALU opcode, plus the ALU arbiter
// state encoding and flag width.
package cpu_types_pkg;

  localparam int WORD_W     = 32;
  localparam int ALU_FLAG_W = 3;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_SLL   = 3'd5,
    ALU_SRL   = 3'd6,
    ALU_PASSB = 3'd7
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef logic [ALU_FLAG_W-1:0] flags_t;

  // Flag vector ordering used everywhere: {of, nf, zf}.
  function automatic flags_t pack_flags(input logic of, input logic nf, input logic zf);
    return {of, nf, zf};
  endfunction

endpackage

// File: rtl/alu_if.sv
// ALU connection: the master drives operands and opcode, the slave (ALU)
// returns the result and its flags.
interface alu_if;
  import cpu_types_pkg::*;

  word_t  porta;
  word_t  portb;
  aluop_t aluop;
  word_t  out;
  logic   zf;
  logic   nf;
  logic   of;

  modport master (
    output porta, portb, aluop,
    input  out, zf, nf, of
  );

  modport slave (
    input  porta, portb, aluop,
    output out, zf, nf, of
  );

endinterface

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way round-robin winner select: a lone requester wins, a tie goes to
// the requester named by prio. Output is one-hot plus a valid bit.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt_oh,
  output logic       vld
);

  always_comb begin
    gnt_oh = 2'b00;
    case (req)
      2'b01:   gnt_oh = 2'b01;
      2'b10:   gnt_oh = 2'b10;
      2'b11:   gnt_oh = prio ? 2'b10 : 2'b01;
      default: gnt_oh = 2'b00;
    endcase
  end

  assign vld = |req;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with round-robin arbitration and a
// held response. Optional grant counters are enabled by ALU_ARB_STATS_EN.
//
// state | meaning
// IDLE  | no transaction; a request is granted combinationally this cycle
// EXEC  | registered operands applied to the ALU
// RESP  | captured result held for the owner until it acknowledges
module alu_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req,
  input  word_t                 porta_i [NREQ-1:0],
  input  word_t                 portb_i [NREQ-1:0],
  input  aluop_t                aluop_i [NREQ-1:0],
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output word_t                 result,
  output logic [ALU_FLAG_W-1:0] flags,
  output logic                  busy,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]           gnt_cnt0,
  output logic [15:0]           gnt_cnt1,
`endif
  alu_if.master                 alif
);

  arb_state_t state_q, state_nxt;
  logic       owner_q;
  logic       prio_q;
  word_t      opa_q;
  word_t      opb_q;
  aluop_t     op_q;

  logic [1:0] pick_oh;
  logic       pick_vld;
  logic       win_idx;
  logic       capture;
  logic       ack;

  rr_pick2 u_pick (
    .req    (req),
    .prio   (prio_q),
    .gnt_oh (pick_oh),
    .vld    (pick_vld)
  );

  assign win_idx = pick_oh[1];
  assign capture = (state_q == IDLE) && pick_vld;
  assign ack     = (state_q == RESP) && rsp_ready[owner_q];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Grant is qualified by reset so nothing pulses while reset is held.
  always_comb begin
    state_nxt = state_q;
    gnt       = '0;
    rsp_valid = '0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld && !RST) begin
          gnt       = pick_oh;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        busy      = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        busy               = 1'b1;
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= ALU_ADD;
      owner_q <= 1'b0;
    end else if (capture) begin
      opa_q   <= porta_i[win_idx];
      opb_q   <= portb_i[win_idx];
      op_q    <= aluop_i[win_idx];
      owner_q <= win_idx;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      result <= '0;
      flags  <= '0;
    end else if (state_q == EXEC) begin
      result <= alif.out;
      flags  <= pack_flags(alif.of, alif.nf, alif.zf);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prio_q <= 1'b0;
    end else if (ack) begin
      prio_q <= ~owner_q;
    end
  end

  assign alif.porta = opa_q;
  assign alif.portb = opb_q;
  assign alif.aluop = op_q;

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gnt_cnt0 <= 16'h0000;
      gnt_cnt1 <= 16'h0000;
    end else begin
      if (gnt[0]) gnt_cnt0 <= gnt_cnt0 + 16'h0001;
      if (gnt[1]) gnt_cnt1 <= gnt_cnt1 + 16'h0001;
    end
  end
`endif

endmodule
